// File: rtl/mem_pkg.sv
// Shared constants and FSM encoding for the byte-wide data memory path.
package mem_pkg;
  localparam int unsigned BASE_ADDR = 1024;
  localparam int unsigned MEM_BYTES = 256;
  localparam int unsigned LANES     = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    XFER = 2'd1,
    DONE = 2'd2
  } state_t;
endpackage

// File: rtl/word_assembler.sv
// 4x8 lane register: one lane written per cycle, synchronous clear; 0-cycle read of held word.
// No backpressure; the owner sequences the lane writes.
module word_assembler
  import mem_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        clr,
  input  logic        wr_en,
  input  logic [1:0]  lane,
  input  logic [7:0]  din,
  output logic [31:0] word
);

  logic [LANES-1:0][7:0] lane_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      lane_q <= '0;
    end else if (clr) begin
      lane_q <= '0;
    end else if (wr_en) begin
      lane_q[lane] <= din;
    end
  end

  assign word = lane_q;

endmodule

// File: rtl/mem_byte_master.sv
// Splits a 32-bit load/store into four byte accesses; DONE 5 cycles after accept (1 if rejected).
// Holds the pipeline with freeze from accept until DONE.
module mem_byte_master #(
  parameter int unsigned  BASE_ADDR = mem_pkg::BASE_ADDR,
  parameter int unsigned  MEM_BYTES = mem_pkg::MEM_BYTES,
  localparam int unsigned AW        = $clog2(MEM_BYTES)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          mem_r_en,
  input  logic          mem_w_en,
  input  logic [31:0]   address,
  input  logic [31:0]   data_to_write,
  output logic [31:0]   result,
  output logic          freeze,
  output logic          addr_err,
  output logic [AW-1:0] bm_addr,
  output logic [7:0]    bm_wdata,
  output logic          bm_we,
  output logic          bm_re,
  input  logic [7:0]    bm_rdata
);
  import mem_pkg::*;

  state_t        state;
  logic [1:0]    cnt;
  logic [AW-1:0] off_q;
  logic [31:0]   data_q;
  logic          wr_q;
  logic          err_q;
  logic [31:0]   result_q;
  logic [31:0]   asm_word;
  logic          req;
  logic          valid;
  logic          xfer;
  logic [31:0]   offset;

  assign req    = mem_w_en | mem_r_en;
  // Unsigned subtraction makes addresses below BASE_ADDR fail the range check too.
  assign offset = address - BASE_ADDR;
  assign valid  = (address[1:0] == 2'b00) && (offset <= MEM_BYTES - LANES);
  assign xfer   = (state == XFER);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= IDLE;
      cnt      <= 2'd0;
      off_q    <= '0;
      data_q   <= '0;
      wr_q     <= 1'b0;
      err_q    <= 1'b0;
      result_q <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (req) begin
            off_q  <= offset[AW-1:0];
            data_q <= data_to_write;
            wr_q   <= mem_w_en;
            err_q  <= !valid;
            cnt    <= 2'd0;
            state  <= valid ? XFER : DONE;
          end
        end
        XFER: begin
          cnt <= cnt + 2'd1;
          if (cnt == 2'd3) state <= DONE;
        end
        DONE: begin
          if (!wr_q && !err_q) result_q <= asm_word;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  word_assembler u_asm (
    .clk   (clk),
    .rst   (rst),
    .clr   ((state == IDLE) && req),
    .wr_en (xfer && !wr_q),
    .lane  (cnt),
    .din   (bm_rdata),
    .word  (asm_word)
  );

  // Reset drops freeze at once so a pipeline held mid-transfer is released.
  assign freeze   = rst && req && (state != DONE);
  assign addr_err = (state == DONE) && err_q;
  assign bm_we    = xfer && wr_q;
  assign bm_re    = xfer && !wr_q;
  assign bm_addr  = xfer ? off_q + AW'(cnt) : '0;
  assign bm_wdata = bm_we ? data_q[{cnt, 3'b000} +: 8] : 8'h00;
  assign result   = (state == DONE && !wr_q && !err_q) ? asm_word : result_q;

endmodule

// File: tb/tb_mem_byte_master.sv
// Directed bench for mem_byte_master with a byte-memory responder and pipeline model.
module tb_mem_byte_master;

  logic        clk;
  logic        rst;
  logic        mem_r_en;
  logic        mem_w_en;
  logic [31:0] address;
  logic [31:0] data_to_write;
  logic [31:0] result;
  logic        freeze;
  logic        addr_err;
  logic [7:0]  bm_addr;
  logic [7:0]  bm_wdata;
  logic        bm_we;
  logic        bm_re;
  logic [7:0]  bm_rdata;

  logic [7:0]  mem [256];
  logic        mem_clr;
  int          cyc = 0;
  int          n_cmp = 0;
  int          n_err = 0;

  int          t_fz;
  int          t_done;
  logic [15:0] t_we;
  logic [15:0] t_re;
  logic [15:0] t_errm;
  logic [31:0] t_addr;
  logic [31:0] t_wdata;
  logic [31:0] t_res;
  int          c0;

  mem_byte_master dut (
    .clk           (clk),
    .rst           (rst),
    .mem_r_en      (mem_r_en),
    .mem_w_en      (mem_w_en),
    .address       (address),
    .data_to_write (data_to_write),
    .result        (result),
    .freeze        (freeze),
    .addr_err      (addr_err),
    .bm_addr       (bm_addr),
    .bm_wdata      (bm_wdata),
    .bm_we         (bm_we),
    .bm_re         (bm_re),
    .bm_rdata      (bm_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk) begin
    if (mem_clr) begin
      for (int k = 0; k < 256; k++) mem[k] <= 8'h00;
    end else if (bm_we) begin
      mem[bm_addr] <= bm_wdata;
    end
  end
  assign bm_rdata = mem[bm_addr];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Present one request, hold it while frozen, record activity per cycle (cycle 0 = accept).
  task automatic run_req(input logic w, input logic r, input logic [31:0] a, input logic [31:0] d);
    mem_w_en = w; mem_r_en = r; address = a; data_to_write = d;
    t_fz = 0; t_done = -1; t_we = '0; t_re = '0; t_errm = '0;
    t_addr = '0; t_wdata = '0; t_res = '0;
    for (int i = 0; i < 12 && t_done < 0; i++) begin
      @(negedge clk);
      if (freeze) t_fz++;
      t_we[i]   = bm_we;
      t_re[i]   = bm_re;
      t_errm[i] = addr_err;
      if (bm_we || bm_re) t_addr = {bm_addr, t_addr[31:8]};
      if (bm_we) t_wdata = {bm_wdata, t_wdata[31:8]};
      if (!freeze) begin
        t_done = i;
        t_res  = result;
      end
    end
    if (t_done < 0) chk("done_timeout", 32'd0, 32'd1);
    @(posedge clk); #1;
    mem_w_en = 1'b0; mem_r_en = 1'b0;
  endtask

  task automatic check_txn(input string tag, input int fz, input int dn,
                           input logic [15:0] we, input logic [15:0] re, input logic [15:0] em,
                           input logic [31:0] ad, input logic [31:0] wd, input logic [31:0] res);
    chk({tag, ".freeze_cycles"}, t_fz, fz);
    chk({tag, ".done_cycle"}, t_done, dn);
    chk({tag, ".we_cycles"}, {16'h0, t_we}, {16'h0, we});
    chk({tag, ".re_cycles"}, {16'h0, t_re}, {16'h0, re});
    chk({tag, ".err_cycles"}, {16'h0, t_errm}, {16'h0, em});
    chk({tag, ".addrs"}, t_addr, ad);
    chk({tag, ".wdata"}, t_wdata, wd);
    chk({tag, ".result"}, t_res, res);
  endtask

  initial begin
    rst = 1'b0; mem_clr = 1'b1;
    mem_r_en = 1'b0; mem_w_en = 1'b0; address = '0; data_to_write = '0;
    #3;
    chk("rst.freeze", {31'd0, freeze}, 32'd0);
    chk("rst.bm_we", {31'd0, bm_we}, 32'd0);
    chk("rst.bm_re", {31'd0, bm_re}, 32'd0);
    chk("rst.bm_addr", {24'd0, bm_addr}, 32'd0);
    chk("rst.bm_wdata", {24'd0, bm_wdata}, 32'd0);
    chk("rst.result", result, 32'd0);
    chk("rst.addr_err", {31'd0, addr_err}, 32'd0);
    @(posedge clk); #1;
    @(posedge clk); #2;
    mem_clr = 1'b0; rst = 1'b1;
    @(posedge clk); #1;

    run_req(1, 0, 32'd1024, 32'hDEADBEEF);
    check_txn("st1024", 5, 5, 16'h001E, 16'h0000, 16'h0000, 32'h03020100, 32'hDEADBEEF, 32'h0);
    run_req(0, 1, 32'd1024, 32'h0);
    check_txn("ld1024", 5, 5, 16'h0000, 16'h001E, 16'h0000, 32'h03020100, 32'h0, 32'hDEADBEEF);
    chk("ld1024.held", result, 32'hDEADBEEF);

    run_req(0, 1, 32'd1026, 32'h0);
    check_txn("ld1026", 1, 1, 16'h0, 16'h0, 16'h0002, 32'h0, 32'h0, 32'hDEADBEEF);
    run_req(0, 1, 32'd1020, 32'h0);
    check_txn("ld1020", 1, 1, 16'h0, 16'h0, 16'h0002, 32'h0, 32'h0, 32'hDEADBEEF);
    run_req(1, 0, 32'd1280, 32'h55AA55AA);
    check_txn("st1280", 1, 1, 16'h0, 16'h0, 16'h0002, 32'h0, 32'h0, 32'hDEADBEEF);
    run_req(1, 0, 32'd1276, 32'h11223344);
    check_txn("st1276", 5, 5, 16'h001E, 16'h0, 16'h0, 32'hFFFEFDFC, 32'h11223344, 32'hDEADBEEF);
    run_req(1, 1, 32'd1028, 32'h01020304);
    check_txn("both1028", 5, 5, 16'h001E, 16'h0, 16'h0, 32'h07060504, 32'h01020304, 32'hDEADBEEF);
    chk("mem.4", {24'd0, mem[4]}, 32'h04);
    chk("mem.7", {24'd0, mem[7]}, 32'h01);

    c0 = cyc;
    run_req(0, 1, 32'd1028, 32'h0);
    check_txn("b2b.ld", 5, 5, 16'h0, 16'h001E, 16'h0, 32'h07060504, 32'h0, 32'h01020304);
    run_req(1, 0, 32'd1032, 32'hCAFEF00D);
    check_txn("b2b.st", 5, 5, 16'h001E, 16'h0, 16'h0, 32'h0B0A0908, 32'hCAFEF00D, 32'h01020304);
    run_req(0, 1, 32'd1032, 32'h0);
    check_txn("b2b.ld2", 5, 5, 16'h0, 16'h001E, 16'h0, 32'h0B0A0908, 32'h0, 32'hCAFEF00D);
    chk("b2b.cycles", cyc - c0, 32'd18);

    // Reset during the third byte of a store.
    mem_w_en = 1'b1; address = 32'd1036; data_to_write = 32'hA1B2C3D4;
    @(posedge clk); @(posedge clk); @(posedge clk); #2;
    chk("mid.pre_we", {31'd0, bm_we}, 32'd1);
    chk("mid.pre_addr", {24'd0, bm_addr}, 32'd14);
    rst = 1'b0; #1;
    chk("mid.bm_we", {31'd0, bm_we}, 32'd0);
    chk("mid.freeze", {31'd0, freeze}, 32'd0);
    chk("mid.result", result, 32'd0);
    mem_w_en = 1'b0;
    @(posedge clk); #3;
    rst = 1'b1;
    @(posedge clk); #1;
    chk("mid.mem12", {24'd0, mem[12]}, 32'hD4);
    chk("mid.mem13", {24'd0, mem[13]}, 32'hC3);
    chk("mid.mem14", {24'd0, mem[14]}, 32'h00);
    chk("mid.mem15", {24'd0, mem[15]}, 32'h00);
    run_req(0, 1, 32'd1036, 32'h0);
    check_txn("post.ld", 5, 5, 16'h0, 16'h001E, 16'h0, 32'h0F0E0D0C, 32'h0, 32'h0000C3D4);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
